// File: rtl/accel_tilt_filter.sv
// Samples raw X/Y tilt at a fixed rate, moving-average filters it, removes the centre offset
// and turns tilt beyond a dead-zone into step strobes whose rate follows tilt magnitude.
// Latency: tilt one cycle after the sample tick, step/dir two cycles after; no backpressure.
module accel_tilt_filter #(
   parameter int SAMPLE_DIV  = 100000,
   parameter int AVG_LOG2    = 3,
   parameter int CENTER      = 256,
   parameter int DEADZONE    = 16,
   parameter int STEP_THRESH = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] accel_x_in,
   input  logic [8:0] accel_y_in,
   output logic [9:0] tilt_x,
   output logic [9:0] tilt_y,
   output logic       sample_valid,
   output logic       step_x,
   output logic       step_y,
   output logic       dir_x,
   output logic       dir_y
);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int PTRW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int HDEP  = 1 << PTRW;
   localparam int CW    = $clog2(SAMPLE_DIV);
   localparam int SW    = 9 + AVG_LOG2;
   localparam int PHW   = $clog2(STEP_THRESH + 256);
   localparam int PSW   = PHW + 1;

   logic [CW-1:0]   div_cnt;
   logic            tick;
   logic            tick_d;
   logic [PTRW-1:0] wr_ptr;
   logic [8:0]      raw      [2];
   logic [8:0]      hist     [2][HDEP];
   logic [SW-1:0]   sum      [2];
   logic [9:0]      tilt     [2];
   logic [PHW-1:0]  phase    [2];
   logic            neg_prev [2];
   logic            step_r   [2];
   logic            dir_r    [2];
   logic            neg      [2];
   logic [9:0]      mag      [2];
   logic [9:0]      eff      [2];
   logic [PSW-1:0]  p_sum    [2];
   logic            step_nxt [2];
   logic [PHW-1:0]  phase_nxt[2];

   assign raw[0] = accel_x_in;
   assign raw[1] = accel_y_in;

   assign tick = (div_cnt == CW'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Running sum swaps the oldest entry for the newest, so no adder tree is needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         for (int a = 0; a < 2; a++) begin
            sum[a] <= SW'(CENTER << AVG_LOG2);
            for (int i = 0; i < HDEP; i++)
               hist[a][i] <= 9'(CENTER);
         end
      end else if (tick) begin
         wr_ptr <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         for (int a = 0; a < 2; a++) begin
            sum[a]          <= sum[a] + SW'(raw[a]) - SW'(hist[a][wr_ptr]);
            hist[a][wr_ptr] <= raw[a];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_d       <= 1'b0;
         sample_valid <= 1'b0;
         tilt[0]      <= '0;
         tilt[1]      <= '0;
      end else begin
         tick_d       <= tick;
         sample_valid <= tick_d;
         if (tick_d)
            for (int a = 0; a < 2; a++)
               tilt[a] <= {1'b0, 9'(sum[a] >> AVG_LOG2)} - 10'(CENTER);
      end
   end

   always_comb begin
      for (int a = 0; a < 2; a++) begin
         neg[a]       = tilt[a][9];
         mag[a]       = neg[a] ? (~tilt[a] + 10'd1) : tilt[a];
         eff[a]       = (mag[a] > 10'(DEADZONE)) ? (mag[a] - 10'(DEADZONE)) : '0;
         p_sum[a]     = {1'b0, phase[a]} + PSW'(eff[a]);
         step_nxt[a]  = 1'b0;
         phase_nxt[a] = phase[a];
         // A direction change restarts accumulation so old tilt never leaks into new steps.
         if ((eff[a] == '0) || (neg[a] != neg_prev[a])) begin
            phase_nxt[a] = '0;
         end else if (p_sum[a] >= PSW'(STEP_THRESH)) begin
            step_nxt[a]  = 1'b1;
            phase_nxt[a] = PHW'(p_sum[a] - PSW'(STEP_THRESH));
         end else begin
            phase_nxt[a] = PHW'(p_sum[a]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int a = 0; a < 2; a++) begin
            phase[a]    <= '0;
            neg_prev[a] <= 1'b0;
            step_r[a]   <= 1'b0;
            dir_r[a]    <= 1'b0;
         end
      end else begin
         for (int a = 0; a < 2; a++) begin
            step_r[a] <= sample_valid & step_nxt[a];
            if (sample_valid) begin
               phase[a]    <= phase_nxt[a];
               neg_prev[a] <= neg[a];
               dir_r[a]    <= !neg[a] && (tilt[a] != '0);
            end
         end
      end
   end

   assign tilt_x = tilt[0];
   assign tilt_y = tilt[1];
   assign step_x = step_r[0];
   assign step_y = step_r[1];
   assign dir_x  = dir_r[0];
   assign dir_y  = dir_r[1];

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Bench for accel_tilt_filter: one fast unfiltered instance against a rule-level model,
// plus a default-depth instance for the averaging ramp and sample period.
module tb_accel_tilt_filter;
   localparam int DIV1 = 4;
   localparam int DIV2 = 6;
   localparam int MD   = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] ax, ay, bx, by;
   logic [9:0] tx, ty, tx2, ty2;
   logic       sv, sx, sy, dx, dy;
   logic       sv2, sx2, sy2, dx2, dy2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   accel_tilt_filter #(.SAMPLE_DIV(DIV1), .AVG_LOG2(0)) dut1 (
      .clk(clk), .reset(rst_n), .accel_x_in(ax), .accel_y_in(ay),
      .tilt_x(tx), .tilt_y(ty), .sample_valid(sv),
      .step_x(sx), .step_y(sy), .dir_x(dx), .dir_y(dy));

   accel_tilt_filter #(.SAMPLE_DIV(DIV2)) dut2 (
      .clk(clk), .reset(rst_n), .accel_x_in(bx), .accel_y_in(by),
      .tilt_x(tx2), .tilt_y(ty2), .sample_valid(sv2),
      .step_x(sx2), .step_y(sy2), .dir_x(dx2), .dir_y(dy2));

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: average of the last MD raw samples, then integer step rules.
   int qx[$];
   int qy[$];
   int m_tilt[2];
   int m_phase[2];
   bit m_negp[2];
   bit m_step[2];
   bit m_dir[2];

   function automatic void model_reset();
      qx = {};
      qy = {};
      for (int i = 0; i < MD; i++) begin
         qx.push_back(256);
         qy.push_back(256);
      end
      for (int a = 0; a < 2; a++) begin
         m_tilt[a] = 0; m_phase[a] = 0; m_negp[a] = 0; m_step[a] = 0; m_dir[a] = 0;
      end
   endfunction

   function automatic void model_tick(input int x, input int y);
      int s0, s1;
      qx.push_back(x); void'(qx.pop_front());
      qy.push_back(y); void'(qy.pop_front());
      s0 = 0; s1 = 0;
      foreach (qx[i]) s0 += qx[i];
      foreach (qy[i]) s1 += qy[i];
      m_tilt[0] = s0 / MD - 256;
      m_tilt[1] = s1 / MD - 256;
      for (int a = 0; a < 2; a++) begin
         int mg, ef;
         bit ng;
         ng = m_tilt[a] < 0;
         mg = ng ? -m_tilt[a] : m_tilt[a];
         ef = (mg > 16) ? mg - 16 : 0;
         m_step[a] = 0;
         if (ef == 0 || ng != m_negp[a]) m_phase[a] = 0;
         else begin
            m_phase[a] += ef;
            if (m_phase[a] >= 1024) begin
               m_step[a] = 1;
               m_phase[a] -= 1024;
            end
         end
         m_negp[a] = ng;
         m_dir[a]  = m_tilt[a] > 0;
      end
   endfunction

   // Holds x/y for n sample ticks of dut1, checking every tick against the model.
   task automatic run_ticks(input int x, input int y, input int n,
                            output int nsx, output int nsy, output int first_sx, output int stray);
      int seen, cyc;
      bit sv_d, es0, es1, ed0, ed1;
      ax = 9'(x); ay = 9'(y);
      nsx = 0; nsy = 0; first_sx = -1; stray = 0; seen = 0; cyc = 0; sv_d = 0;
      es0 = 0; es1 = 0; ed0 = 0; ed1 = 0;
      while ((seen < n || sv_d) && cyc < n * DIV1 * 2 + 20) begin
         @(negedge clk);
         cyc++;
         if (sv_d) begin
            chk("step_x", int'(sx), int'(es0));
            chk("step_y", int'(sy), int'(es1));
            chk("dir_x", int'(dx), int'(ed0));
            chk("dir_y", int'(dy), int'(ed1));
            if (sx) begin
               nsx++;
               if (first_sx < 0) first_sx = seen - 1;
            end
            if (sy) nsy++;
         end else if (sx || sy) begin
            stray++;
         end
         sv_d = sv;
         if (sv) begin
            model_tick(x, y);
            seen++;
            chk("tilt_x", int'($signed(tx)), m_tilt[0]);
            chk("tilt_y", int'($signed(ty)), m_tilt[1]);
            es0 = m_step[0]; es1 = m_step[1]; ed0 = m_dir[0]; ed1 = m_dir[1];
         end
      end
      chk("tick_budget", seen, n);
      chk("steps_outside_slot", stray, 0);
   endtask

   typedef struct {
      int x; int y; int n; int etx; int ety; int esx; int esy;
   } vec_t;

   vec_t tbl[7];
   int   ramp[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nsx, nsy, first, stray, c, per;
      bit got1, got2, pend, ok;

      // Direction-change rows run one extra tick: the reversal tick only clears phase.
      tbl[0] = '{356, 256, 1024,  100,   0,  84, 0};
      tbl[1] = '{200, 256, 1025,  -56,   0,  40, 0};
      tbl[2] = '{266, 256,   64,   10,   0,   0, 0};
      tbl[3] = '{511, 256, 1024,  255,   0, 239, 0};
      tbl[4] = '{  0, 256, 1025, -256,   0, 240, 0};
      tbl[5] = '{272, 240,   64,   16, -16,   0, 0};
      tbl[6] = '{273, 239,   64,   17, -17,   0, 0};
      ramp   = '{12, 25, 37, 50, 62, 75, 87, 100};

      // Reset with inputs off-centre: everything reads zero.
      rst_n = 1'b0;
      ax = 9'd400; ay = 9'd400; bx = 9'd400; by = 9'd400;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_tilt_x", int'(tx), 0);
      chk("rst_tilt_y", int'(ty), 0);
      chk("rst_outputs", int'({sv, sx, sy, dx, dy}), 0);

      // Let history fill with 400, then reset mid-sample and confirm it is discarded.
      rst_n = 1'b1;
      run_ticks(400, 400, 3, nsx, nsy, first, stray);
      chk("pre_reset_tilt_x", int'($signed(tx)), 144);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tilt_x", int'(tx), 0);
      chk("async_rst_tilt_x2", int'(tx2), 0);
      chk("async_rst_dir", int'({dx, dy}), 0);
      model_reset();
      bx = 9'd256; by = 9'd256;
      @(negedge clk);
      rst_n = 1'b1;

      // First tick timing; dut2 history must be back to centre.
      got1 = 0; got2 = 0; pend = 0; c = 0;
      while (!(got1 && got2 && !pend) && c < 20) begin
         @(negedge clk);
         c++;
         if (pend) begin
            chk("first_step_x", int'(sx), int'(m_step[0]));
            chk("first_dir_x", int'(dx), int'(m_dir[0]));
            pend = 0;
         end
         if (!got1) begin
            if (sv) begin
               got1 = 1;
               chk("first_tick_cycle", c, DIV1 + 1);
               model_tick(400, 400);
               chk("first_tilt_x", int'($signed(tx)), m_tilt[0]);
               pend = 1;
            end else begin
               chk("tilt_x_before_tick", int'(tx), 0);
            end
         end
         if (!got2 && sv2) begin
            got2 = 1;
            chk("tilt_x2_after_reset", int'(tx2), 0);
         end
      end
      chk("first_ticks_seen", int'(got1 && got2), 1);
      run_ticks(256, 256, 2, nsx, nsy, first, stray);

      // Table: long holds, extremes, dead-zone boundaries.
      for (int i = 0; i < 7; i++) begin
         run_ticks(tbl[i].x, tbl[i].y, tbl[i].n, nsx, nsy, first, stray);
         chk($sformatf("tbl%0d_tilt_x", i), int'($signed(tx)), tbl[i].etx);
         chk($sformatf("tbl%0d_tilt_y", i), int'($signed(ty)), tbl[i].ety);
         chk($sformatf("tbl%0d_steps_x", i), nsx, tbl[i].esx);
         chk($sformatf("tbl%0d_steps_y", i), nsy, tbl[i].esy);
      end

      // Reversal: phase clears, then 13 accumulations of 84 reach the threshold.
      run_ticks(356, 256, 10, nsx, nsy, first, stray);
      run_ticks(156, 256, 20, nsx, nsy, first, stray);
      chk("reversal_first_step_tick", first, 13);
      chk("reversal_dir_x", int'(dx), 0);

      // Randomised holds against the model.
      for (int i = 0; i < 24; i++)
         run_ticks(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                   int'($urandom_range(1, 30)), nsx, nsy, first, stray);

      // Default-depth averaging ramp and sample period on dut2.
      c = 0;
      while (!sv2 && c < 4 * DIV2) begin
         @(negedge clk);
         c++;
      end
      chk("dut2_sync", int'(sv2), 1);
      chk("dut2_level_tilt", int'($signed(tx2)), 0);
      bx = 9'd356;
      for (int k = 0; k < 8; k++) begin
         per = 0;
         ok = 0;
         while (!ok && per < 4 * DIV2) begin
            @(negedge clk);
            per++;
            ok = sv2;
         end
         chk($sformatf("ramp%0d_period", k), per, DIV2);
         chk($sformatf("ramp%0d_tilt_x2", k), int'($signed(tx2)), ramp[k]);
      end
      chk("dut2_tilt_y2", int'($signed(ty2)), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
